// File: rtl/pac_referee.sv
// pac_referee: game-rule stage for the pac-man maze.
// Samples pac and ghost cells on i_tick and keeps the pellet map, score, lives
// and pellets remaining. Sequences IDLE/PLAY/HIT/OVER/WIN, and drives o_freeze back to the movers.
// Optional feature: define PAC_REFEREE_SWAP_DETECT_EN to also count sprites that swap cells
// in one tick as a collision. This adds the previous-position registers.
module pac_referee #(
    parameter int unsigned GRID_W     = 5,
    parameter int unsigned GRID_H     = 5,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned HIT_TICKS  = 4,
    parameter int unsigned PELLET_PTS = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_tick,
    input  logic [5:0] i_pac_x,
    input  logic [5:0] i_pac_y,
    input  logic [5:0] i_ghost_x,
    input  logic [5:0] i_ghost_y,
    output logic [2:0] o_state,
    output logic [9:0] o_score,
    output logic [1:0] o_lives,
    output logic [5:0] o_pellets_left,
    output logic       o_eat,
    output logic       o_hit,
    output logic       o_freeze
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_HIT  = 3'd2;
    localparam logic [2:0] S_OVER = 3'd3;
    localparam logic [2:0] S_WIN  = 3'd4;

    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned HCW   = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    // The map bit for cell (x,y) is y*GRID_W+x. The pac start cell is the top bit, and it starts empty.
    localparam logic [CELLS-1:0] MAP_INIT     = {1'b0, {(CELLS-1){1'b1}}};
    localparam logic [CELLS-1:0] CELL0        = {{(CELLS-1){1'b0}}, 1'b1};
    localparam logic [5:0]       PELLETS_INIT = 6'(CELLS - 1);
    localparam logic [1:0]       LIVES_INIT   = 2'(LIVES);
    localparam logic [5:0]       PAC_X0       = 6'(GRID_W - 1);
    localparam logic [5:0]       PAC_Y0       = 6'(GRID_H - 1);

    logic [2:0]       state_q, state_d;
    logic [9:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic [5:0]       pellets_q, pellets_d;
    logic [CELLS-1:0] map_q, map_d;
    logic [HCW-1:0]   hit_cnt_q, hit_cnt_d;
    logic             eat_q, eat_d;
    logic             hit_q, hit_d;

    logic             start_ok;
    logic             pac_in_range;
    int unsigned      pac_idx;
    logic [CELLS-1:0] pac_sel;
    logic             pellet_here;
    logic             same_cell;
    logic             collide;
    logic [10:0]      score_sum;
    logic [9:0]       score_sat;
    logic             hit_cnt_last;

    assign start_ok = i_start &&
                      (state_q == S_IDLE || state_q == S_OVER || state_q == S_WIN);

    // Pac cell one-hot into the map. An out-of-range cell selects nothing.
    assign pac_in_range = (32'(i_pac_x) < GRID_W) && (32'(i_pac_y) < GRID_H);
    assign pac_idx      = 32'(i_pac_y) * GRID_W + 32'(i_pac_x);
    assign pac_sel      = pac_in_range ? (CELL0 << pac_idx) : '0;
    assign pellet_here  = |(map_q & pac_sel);

    assign same_cell = (i_pac_x == i_ghost_x) && (i_pac_y == i_ghost_y);

`ifdef PAC_REFEREE_SWAP_DETECT_EN
    logic [5:0] pac_prev_x_q, pac_prev_y_q, ghost_prev_x_q, ghost_prev_y_q;
    logic       swapped;

    assign swapped = (i_pac_x == ghost_prev_x_q) && (i_pac_y == ghost_prev_y_q) &&
                     (i_ghost_x == pac_prev_x_q) && (i_ghost_y == pac_prev_y_q);
    assign collide = same_cell || swapped;

    // Previous cells follow every tick. A restart returns them to the start cells.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pac_prev_x_q   <= PAC_X0;
            pac_prev_y_q   <= PAC_Y0;
            ghost_prev_x_q <= '0;
            ghost_prev_y_q <= '0;
        end else if (start_ok) begin
            pac_prev_x_q   <= PAC_X0;
            pac_prev_y_q   <= PAC_Y0;
            ghost_prev_x_q <= '0;
            ghost_prev_y_q <= '0;
        end else if (i_tick) begin
            pac_prev_x_q   <= i_pac_x;
            pac_prev_y_q   <= i_pac_y;
            ghost_prev_x_q <= i_ghost_x;
            ghost_prev_y_q <= i_ghost_y;
        end
    end
`else
    assign collide = same_cell;
`endif

    assign score_sum    = {1'b0, score_q} + 11'(PELLET_PTS);
    assign score_sat    = (score_sum > 11'd1023) ? '1 : score_sum[9:0];
    assign hit_cnt_last = (32'(hit_cnt_q) == HIT_TICKS - 1);

    // Game rules: restart, then collision-before-eat in PLAY, then tick counting in HIT.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        pellets_d = pellets_q;
        map_d     = map_q;
        hit_cnt_d = hit_cnt_q;
        eat_d     = 1'b0;
        hit_d     = 1'b0;
        if (start_ok) begin
            state_d   = S_PLAY;
            score_d   = '0;
            lives_d   = LIVES_INIT;
            pellets_d = PELLETS_INIT;
            map_d     = MAP_INIT;
            hit_cnt_d = '0;
        end else if (i_tick) begin
            case (state_q)
                S_PLAY: begin
                    if (collide) begin
                        hit_d     = 1'b1;
                        lives_d   = lives_q - 2'd1;
                        hit_cnt_d = '0;
                        state_d   = (lives_q == 2'd1) ? S_OVER : S_HIT;
                    end else if (pellet_here) begin
                        eat_d     = 1'b1;
                        map_d     = map_q & ~pac_sel;
                        score_d   = score_sat;
                        pellets_d = pellets_q - 6'd1;
                        if (pellets_q == 6'd1) begin
                            state_d = S_WIN;
                        end
                    end
                end
                S_HIT: begin
                    if (hit_cnt_last) begin
                        state_d = S_PLAY;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Game registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            lives_q   <= LIVES_INIT;
            pellets_q <= PELLETS_INIT;
            map_q     <= MAP_INIT;
            hit_cnt_q <= '0;
            eat_q     <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            pellets_q <= pellets_d;
            map_q     <= map_d;
            hit_cnt_q <= hit_cnt_d;
            eat_q     <= eat_d;
            hit_q     <= hit_d;
        end
    end

    assign o_state        = state_q;
    assign o_score        = score_q;
    assign o_lives        = lives_q;
    assign o_pellets_left = pellets_q;
    assign o_eat          = eat_q;
    assign o_hit          = hit_q;
    assign o_freeze       = (state_q != S_PLAY);

endmodule

// File: doc/pac_referee.md
# pac_referee

Game-rule stage downstream of the pac-man and ghost movers. It samples both sprites' grid coordinates on a tick strobe and keeps a 5x5 pellet map, the score, lives and the pellets remaining. It detects pac/ghost collisions and sequences the game through idle, play, hit, over and win. Its freeze output feeds back to the movers, and its counters drive the seven-segment decoders.

## Interface
- GRID_W, 5, grid columns (x range 0..GRID_W-1)
- GRID_H, 5, grid rows (y range 0..GRID_H-1)
- LIVES, 3, lives loaded at game start (1..3)
- HIT_TICKS, 4, ticks spent in HIT before play resumes (>=1)
- PELLET_PTS, 10, score added per pellet
---
- i_clk  in  1  system clock (CLOCK_50 domain)
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse: start or restart the game
- i_tick  in  1  one-cycle strobe: positions valid this cycle
- i_pac_x, i_pac_y  in  6 each  pac-man cell
- i_ghost_x, i_ghost_y  in  6 each  ghost cell
- o_state  out  3  IDLE=0, PLAY=1, HIT=2, OVER=3, WIN=4
- o_score  out  10  score, saturates at 1023
- o_lives  out  2  lives remaining
- o_pellets_left  out  6  uneaten pellets
- o_eat  out  1  one-cycle pulse: pellet eaten
- o_hit  out  1  one-cycle pulse: collision
- o_freeze  out  1  high whenever state != PLAY; movers hold position

## Operation
- Reset values: state IDLE, score 0, lives LIVES, pellet map full except the pac start cell (GRID_W-1, GRID_H-1), pellets_left GRID_W*GRID_H-1 (24), eat/hit 0, freeze 1. Previous-position registers hold the start cells: pac (4,4), ghost (0,0).
- i_start in IDLE, OVER or WIN reloads all counters and the map to their reset values, then enters PLAY. i_start in PLAY or HIT is ignored.
- PLAY, on i_tick. Evaluation priority:
  1. Collision when pac cell == ghost cell (all 6 bits compared). Assert o_hit and decrement lives. If the new lives value is 0, go to OVER; otherwise go to HIT. No pellet is eaten on a collision tick.
  2. Otherwise, if pac x < GRID_W, pac y < GRID_H and the map bit is set: clear the bit, add PELLET_PTS to score (saturating), decrement pellets_left and assert o_eat. If pellets_left reaches 0, go to WIN.
  3. Out-of-range pac coordinates never eat and never index the map.
- HIT: counts i_tick pulses. On the HIT_TICKS-th tick, return to PLAY. Map, score and lives are unchanged.
- OVER and WIN are terminal until i_start.
- i_tick outside PLAY and HIT has no effect, apart from updating the previous-position registers.

## Timing
- i_tick at cycle N updates every output at the rising edge ending cycle N. The outputs are visible at N+1, with a latency of 1 cycle.
- o_eat and o_hit are high for exactly cycle N+1.
- If i_start and i_tick arrive in the same cycle in IDLE, OVER or WIN, i_start wins and the tick is discarded.
- An asynchronous reset asserted mid-game returns every register to its reset value immediately. Nothing is evaluated until reset is released.
- score saturates: with score=1020 and PELLET_PTS=10, the next eat yields 1023.

## Configuration
- PAC_REFEREE_SWAP_DETECT_EN defined:
  - Registers the previous pac and ghost cells on every i_tick.
  - Also counts a collision when pac_now == ghost_prev and ghost_now == pac_prev, which catches sprites passing through each other.
  - Priority and effects are identical to a same-cell collision.
- Undefined: only same-cell collisions count, and the previous-position registers are omitted.

## Test plan
- Reset, then i_start → state=1, lives=3, pellets_left=24, score=0, freeze=0.
- Tick with pac (3,4), ghost (0,0) → o_eat pulse, score=10, pellets_left=23. Repeat tick at (3,4) → no eat, score stays 10.
- Tick with pac=ghost=(2,2) → o_hit, lives=2, state=HIT. Four ticks later → state=PLAY, pellets unchanged.
- Three collisions → lives=0, state=OVER, freeze=1. i_start → full reload, state=PLAY.
- Eat all 24 pellets → state=WIN after the 24th tick. Pac at (7,1) → no eat, no map change.
- With the macro defined: tick pac (1,1)/ghost (1,2), then pac (1,2)/ghost (1,1) → o_hit. Without the macro → no hit.
